div8_stream_ctrl: RTL and testbench

Sequential front/back end for the combinational 8-bit/8-bit quotient-only divider core. It accepts operand pairs over a valid/ready stream and registers them onto the core's 16 inputs. It holds them for a programmable settle window, then captures the 8-bit quotient. It derives the remainder, self-checks the core result, and presents {quotient, remainder, flags} on an output valid/ready stream.

---
 rtl/div8_stream_ctrl.sv | 171 +++++++++++++++++
 tb/tb_div8_stream_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div8_stream_ctrl.sv
// div8_stream_ctrl: valid/ready wrapper around a combinational 8/8 quotient-only
// divider core. Operands are registered onto the core inputs, held for a settle
// window, then the quotient is captured, the remainder derived and the core
// result cross-checked against q*b + r == a with 0 <= r < b.
module div8_stream_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_dividend,
  input  logic [7:0]  in_divisor,
  output logic [15:0] div_x,
  input  logic [7:0]  div_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_quot,
  output logic [7:0]  out_rem,
  output logic        out_dz,
  output logic        out_chk_err,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic [7:0]  quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        dz_q, dz_d;
  logic        chk_q, chk_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        capture_s;

  logic [15:0] prod_s;
  logic [16:0] diff_s;
  logic [7:0]  res_quot_s;
  logic [7:0]  res_rem_s;
  logic        res_dz_s;
  logic        res_chk_s;

  // Result derivation from the held operands and the core quotient.
  always_comb begin
    prod_s     = {8'd0, div_y} * {8'd0, opb_q};
    diff_s     = {9'd0, opa_q} - {1'b0, prod_s};
    res_quot_s = div_y;
    res_rem_s  = diff_s[7:0];
    res_dz_s   = 1'b0;
    res_chk_s  = 1'b0;
    if (opb_q == 8'd0) begin
      // Divide by zero: fixed encoding, core output is not trusted.
      res_quot_s = 8'hFF;
      res_rem_s  = opa_q;
      res_dz_s   = 1'b1;
      res_chk_s  = 1'b0;
    end else if (diff_s[16]) begin
      // q*b exceeds a: quotient too large.
      res_chk_s = 1'b1;
    end else if (diff_s[15:0] >= {8'd0, opb_q}) begin
      // Remainder not below divisor: quotient too small.
      res_chk_s = 1'b1;
    end else begin
      res_chk_s = 1'b0;
    end
  end

  // Next-state, operand latch, settle countdown and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    chk_d     = chk_q;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = in_dividend;
          opb_d   = in_divisor;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          capture_s = 1'b1;
          quot_d    = res_quot_s;
          rem_d     = res_rem_s;
          dz_d      = res_dz_s;
          chk_d     = res_chk_s;
          state_d   = DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating check-error counter; clear wins over a coincident increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'd0;
    end else if (capture_s && res_chk_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      opa_q     <= 8'd0;
      opb_q     <= 8'd0;
      quot_q    <= 8'd0;
      rem_q     <= 8'd0;
      dz_q      <= 1'b0;
      chk_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      chk_q     <= chk_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign div_x       = {opb_q, opa_q};
  assign out_quot    = quot_q;
  assign out_rem     = rem_q;
  assign out_dz      = dz_q;
  assign out_chk_err = chk_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_div8_stream_ctrl.sv
// Directed testbench for div8_stream_ctrl with a behavioural divider core
// whose output can be overridden to inject faults.
module tb_div8_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_dividend;
  logic [7:0]  in_divisor;
  logic [15:0] div_x;
  logic [7:0]  div_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_quot;
  logic [7:0]  out_rem;
  logic        out_dz;
  logic        out_chk_err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  logic        force_en;
  logic [7:0]  force_val;
  logic [7:0]  core_q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;

  div8_stream_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_x(div_x), .div_y(div_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .out_dz(out_dz),
    .out_chk_err(out_chk_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency / spacing measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider core with fault override.
  always_comb begin
    if (div_x[15:8] == 8'd0) core_q = 8'hFF;
    else core_q = div_x[7:0] / div_x[15:8];
    div_y = force_en ? force_val : core_q;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_div_x"}, div_x, 0);
    check_eq({tag, "_quot"}, out_quot, 0);
    check_eq({tag, "_rem"}, out_rem, 0);
    check_eq({tag, "_dz"}, out_dz, 0);
    check_eq({tag, "_chk"}, out_chk_err, 0);
    check_eq({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // Send one operand pair, measure latency, check result; optionally handshake.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic echk, input logic release_out);
    int lat;
    check_eq({tag, "_in_ready"}, in_ready, 1);
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    @(posedge clk);
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    #1;
    in_valid = 1'b0;
    check_eq({tag, "_div_x"}, div_x, {b, a});
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 2);
    check_eq({tag, "_quot"}, out_quot, eq);
    check_eq({tag, "_rem"}, out_rem, er);
    check_eq({tag, "_dz"}, out_dz, edz);
    check_eq({tag, "_chk"}, out_chk_err, echk);
    if (release_out) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq({tag, "_ready_after"}, in_ready, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_dividend = 8'd0; in_divisor = 8'd0;
    out_ready = 1'b0; err_clr = 1'b0; force_en = 1'b0; force_val = 8'd0;
    step(); step();
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();
    check_reset_vals("post_rst");

    // Basic operation
    run_op("op200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 1'b1);

    // Back-to-back with out_ready held high: acceptances 4 cycles apart
    out_ready = 1'b1;
    run_op("b2b_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    run_op("b2b_3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0);
    check_eq("b2b_spacing1", acc_cyc - prev_acc, 4);
    step();
    run_op("b2b_0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_eq("b2b_spacing2", acc_cyc - prev_acc, 4);
    step();
    out_ready = 1'b0;
    check_eq("b2b_idle", in_ready, 1);

    // One fault: q=30 for 200/7 -> d=-10, rem byte 0xF6
    force_en = 1'b1; force_val = 8'd30;
    run_op("fault1", 8'd200, 8'd7, 8'd30, 8'hF6, 1'b0, 1'b1, 1'b1);
    check_eq("fault1_err_cnt", err_cnt, 1);

    // Divide by zero with core forced to 0: err_cnt unchanged
    force_val = 8'h00;
    run_op("dz5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0, 1'b1);
    check_eq("dz_err_cnt", err_cnt, 1);

    // Under-estimated quotient: q=27 for 200/7 -> rem 11 >= 7
    force_val = 8'd27;
    run_op("fault_lo", 8'd200, 8'd7, 8'd27, 8'd11, 1'b0, 1'b1, 1'b1);
    check_eq("fault_lo_err_cnt", err_cnt, 2);

    // Saturation: 298 more faults -> total 300
    force_val = 8'd30;
    out_ready = 1'b1;
    for (int i = 0; i < 298; i++) begin
      in_dividend = 8'd200; in_divisor = 8'd7; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
    end
    out_ready = 1'b0;
    check_eq("sat_err_cnt", err_cnt, 255);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("clr_err_cnt", err_cnt, 0);

    // err_clr coincident with a check-error capture
    err_clr = 1'b1;
    run_op("clr_coinc", 8'd200, 8'd7, 8'd30, 8'hF6, 1'b0, 1'b1, 1'b1);
    err_clr = 1'b0;
    check_eq("clr_coinc_err_cnt", err_cnt, 0);
    force_en = 1'b0;

    // Backpressure: result held, in_valid ignored
    run_op("bp100_3", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b0, 1'b0);
    in_dividend = 8'd9; in_divisor = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_quot", out_quot, 33);
      check_eq("bp_rem", out_rem, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_div_x", div_x, {8'd3, 8'd100});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_release_ready", in_ready, 1);
    check_eq("bp_release_valid", out_valid, 0);
    check_eq("bp_no_accept", div_x, {8'd3, 8'd100});

    // Reset mid-SETTLE with nonzero err_cnt
    force_en = 1'b1; force_val = 8'd30;
    run_op("pre_rst_fault", 8'd200, 8'd7, 8'd30, 8'hF6, 1'b0, 1'b1, 1'b1);
    check_eq("pre_rst_err_cnt", err_cnt, 1);
    force_en = 1'b0;
    in_dividend = 8'd77; in_divisor = 8'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("mid_settle_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("post_rst_no_result", out_valid, 0);
    end
    run_op("fresh77_5", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
